// File: rtl/input_packer.sv
// Packs NC WF-bit features, one per handshake, into an NC*WF sample vector.
// The vector is presented on a registered valid/ready master port.
module input_packer #(
    parameter int    NC    = 7,
    parameter int    WF    = 5,
    parameter string BURST = "yes"
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iValid_AM_Elem,
    output logic                      oReady_AM_Elem,
    input  logic [WF-1:0]             iData_AM_Elem,
    input  logic                      iLast_AM_Elem,
    output logic                      oValid_BM_Sample,
    input  logic                      iReady_BM_Sample,
    output logic [NC*WF-1:0]          oData_BM_Sample,
    output logic [$clog2(NC+1)-1:0]   oFill
);

    localparam int            CW       = $clog2(NC + 1);
    localparam logic [CW-1:0] LastLane = CW'(NC - 1);
    localparam bit            BurstEn  = (BURST == "yes");

    logic [CW-1:0]    count_q, count_d;
    logic [NC*WF-1:0] pack_q, pack_d;
    logic [NC*WF-1:0] outData_q, outData_d;
    logic             outValid_q, outValid_d;

    logic             closing;
    logic             elemReady;
    logic             accept;
    logic             drain;
    logic [NC*WF-1:0] nextVec;

    // The closing feature needs room in the output register; earlier lanes never wait on it.
    always_comb begin
        closing = (count_q == LastLane) || iLast_AM_Elem;
        if (closing) begin
            elemReady = BurstEn ? (!outValid_q || iReady_BM_Sample) : !outValid_q;
        end else begin
            elemReady = 1'b1;
        end
        accept = iValid_AM_Elem && elemReady;
        drain  = outValid_q && iReady_BM_Sample;
    end

    always_comb begin
        nextVec = pack_q;
        for (int k = 0; k < NC; k++) begin
            if (CW'(k) == count_q) begin
                nextVec[k*WF +: WF] = iData_AM_Elem;
            end else if ((CW'(k) > count_q) && closing) begin
                nextVec[k*WF +: WF] = '0;
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        pack_d     = pack_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        if (drain) begin
            outValid_d = 1'b0;
        end
        // A close in the same cycle as a drain reloads the register, keeping valid high.
        if (accept) begin
            if (closing) begin
                outData_d  = nextVec;
                outValid_d = 1'b1;
                count_d    = '0;
                pack_d     = '0;
            end else begin
                pack_d  = nextVec;
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            count_q    <= '0;
            pack_q     <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            pack_q     <= pack_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
        end
    end

    assign oReady_AM_Elem   = elemReady;
    assign oValid_BM_Sample = outValid_q;
    assign oData_BM_Sample  = outData_q;
    assign oFill            = count_q;

endmodule

// File: tb/tb_input_packer.sv
// Self-checking bench for input_packer: directed scenarios plus a randomly
// throttled stream, with a scoreboard fed from accepted features.
module tb_input_packer;

    localparam int NC = 7;
    localparam int WF = 5;
    localparam int CW = $clog2(NC + 1);

    logic             clk;
    logic             rst_n;
    logic             inValid;
    logic             inReady;
    logic [WF-1:0]    inData;
    logic             inLast;
    logic             outValid;
    logic             outReady;
    logic [NC*WF-1:0] outData;
    logic [CW-1:0]    fill;

    int total = 0;
    int bad   = 0;
    int outCount = 0;

    logic [NC*WF-1:0] sb[$];
    logic [NC*WF-1:0] modelVec;
    int               modelLane;
    logic             holdValid;
    logic [NC*WF-1:0] holdData;

    input_packer #(.NC(NC), .WF(WF), .BURST("yes")) dut (
        .iCLK             (clk),
        .iRST             (rst_n),
        .iValid_AM_Elem   (inValid),
        .oReady_AM_Elem   (inReady),
        .iData_AM_Elem    (inData),
        .iLast_AM_Elem    (inLast),
        .oValid_BM_Sample (outValid),
        .iReady_BM_Sample (outReady),
        .oData_BM_Sample  (outData),
        .oFill            (fill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Mid-cycle monitor: inputs change at posedge+1, so the negedge sees what the next edge commits.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            modelVec  = '0;
            modelLane = 0;
            holdValid = 1'b0;
        end else begin
            if (holdValid) begin
                total++;
                if (outValid !== 1'b1 || outData !== holdData) begin
                    bad++;
                    $display("[TB] FAIL hold_stable: valid=%0b data=%h required valid=1 data=%h", outValid, outData, holdData);
                end
            end
            if (outValid && outReady) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_vector: got %h with empty scoreboard", outData);
                end else begin
                    logic [NC*WF-1:0] exp;
                    exp = sb.pop_front();
                    outCount++;
                    if (outData !== exp) begin
                        bad++;
                        $display("[TB] FAIL vector_data: got %h required %h", outData, exp);
                    end
                end
            end
            holdValid = outValid && !outReady;
            holdData  = outData;
            if (inValid && inReady) begin
                modelVec[modelLane*WF +: WF] = inData;
                if (modelLane == NC - 1 || inLast) begin
                    sb.push_back(modelVec);
                    modelVec  = '0;
                    modelLane = 0;
                end else begin
                    modelLane++;
                end
            end
        end
    end

    task automatic sendFeature(input logic [WF-1:0] d, input logic l);
        int  waitCnt;
        bit  done;
        waitCnt = 0;
        done    = 1'b0;
        inValid = 1'b1;
        inData  = d;
        inLast  = l;
        while (!done) begin
            @(negedge clk);
            if (inReady) done = 1'b1;
            @(posedge clk);
            #1;
            if (!done) begin
                waitCnt++;
                if (waitCnt > 500) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL accept_timeout: feature %h not accepted, required acceptance within 500 cycles", d);
                    done = 1'b1;
                end
            end
        end
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total += 4;
        if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b required 0", outValid); end
        if (outData !== '0) begin bad++; $display("[TB] FAIL reset_data: got %h required 0", outData); end
        if (fill !== '0) begin bad++; $display("[TB] FAIL reset_fill: got %0d required 0", fill); end
        if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b required 1", inReady); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full_sample();
        logic [NC*WF-1:0] exp;
        outReady = 1'b1;
        for (int k = 0; k < NC; k++) exp[k*WF +: WF] = WF'(k + 1);
        for (int k = 0; k < NC - 1; k++) sendFeature(WF'(k + 1), 1'b0);
        total += 2;
        if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL full_early_valid: got %b required 0", outValid); end
        if (fill !== CW'(6)) begin bad++; $display("[TB] FAIL full_fill6: got %0d required 6", fill); end
        sendFeature(WF'(7), 1'b1);
        total += 3;
        if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL full_valid: got %b required 1", outValid); end
        if (outData !== exp) begin bad++; $display("[TB] FAIL full_data: got %h required %h", outData, exp); end
        if (fill !== '0) begin bad++; $display("[TB] FAIL full_fill0: got %0d required 0", fill); end
        @(posedge clk);
        #1;
        total++;
        if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL full_valid_one_cycle: got %b required 0", outValid); end
    endtask

    task automatic test_short_sample();
        logic [NC*WF-1:0] exp;
        exp = '0;
        exp[0 +: WF]  = WF'(3);
        exp[WF +: WF] = WF'(9);
        outReady = 1'b1;
        sendFeature(WF'(3), 1'b0);
        total++;
        if (fill !== CW'(1)) begin bad++; $display("[TB] FAIL short_fill1: got %0d required 1", fill); end
        sendFeature(WF'(9), 1'b1);
        total += 3;
        if (fill !== '0) begin bad++; $display("[TB] FAIL short_fill0: got %0d required 0", fill); end
        if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL short_valid: got %b required 1", outValid); end
        if (outData !== exp) begin bad++; $display("[TB] FAIL short_data: got %h required %h", outData, exp); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [NC*WF-1:0] exp2;
        for (int k = 0; k < NC; k++) exp2[k*WF +: WF] = WF'(10 + k);
        outReady = 1'b0;
        for (int k = 0; k < NC; k++) sendFeature(WF'(20 + k), k == NC - 1);
        for (int k = 0; k < NC - 1; k++) sendFeature(WF'(10 + k), 1'b0);
        total += 2;
        if (fill !== CW'(6)) begin bad++; $display("[TB] FAIL bp_fill6: got %0d required 6", fill); end
        if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL bp_held_valid: got %b required 1", outValid); end
        inValid = 1'b1;
        inData  = WF'(16);
        inLast  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_low: got %b required 0", inReady); end
            @(posedge clk);
            #1;
        end
        outReady = 1'b1;
        @(negedge clk);
        total++;
        if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_burst: got %b required 1", inReady); end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        total += 3;
        if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL bp_reload_valid: got %b required 1", outValid); end
        if (outData !== exp2) begin bad++; $display("[TB] FAIL bp_reload_data: got %h required %h", outData, exp2); end
        if (fill !== '0) begin bad++; $display("[TB] FAIL bp_fill0: got %0d required 0", fill); end
        @(posedge clk);
        #1;
        total++;
        if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained: got %b required 0", outValid); end
    endtask

    task automatic test_back_to_back();
        int validAt[$];
        outReady = 1'b1;
        for (int i = 0; i < 3 * NC; i++) begin
            inValid = 1'b1;
            inData  = WF'(i + 1);
            inLast  = 1'b0;
            @(negedge clk);
            total++;
            if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready: feature %0d got %b required 1", i, inReady); end
            @(posedge clk);
            #1;
            if (outValid) validAt.push_back(i);
        end
        inValid = 1'b0;
        total++;
        if (validAt.size() != 3) begin
            bad++;
            $display("[TB] FAIL b2b_vector_count: got %0d required 3", validAt.size());
        end else begin
            total += 2;
            if (validAt[1] - validAt[0] != NC) begin bad++; $display("[TB] FAIL b2b_spacing1: got %0d required %0d", validAt[1] - validAt[0], NC); end
            if (validAt[2] - validAt[1] != NC) begin bad++; $display("[TB] FAIL b2b_spacing2: got %0d required %0d", validAt[2] - validAt[1], NC); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        logic [NC*WF-1:0] exp;
        outReady = 1'b0;
        for (int k = 0; k < NC; k++) sendFeature(WF'(k + 2), 1'b0);
        for (int k = 0; k < 4; k++) sendFeature(WF'(k + 25), 1'b0);
        total += 2;
        if (fill !== CW'(4)) begin bad++; $display("[TB] FAIL ar_fill4: got %0d required 4", fill); end
        if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL ar_pending: got %b required 1", outValid); end
        #2;
        rst_n = 1'b0;
        #1;
        total += 3;
        if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL ar_valid: got %b required 0", outValid); end
        if (fill !== '0) begin bad++; $display("[TB] FAIL ar_fill: got %0d required 0", fill); end
        if (outData !== '0) begin bad++; $display("[TB] FAIL ar_data: got %h required 0", outData); end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        outReady = 1'b1;
        exp = '0;
        exp[0 +: WF] = WF'(17);
        sendFeature(WF'(17), 1'b1);
        total += 2;
        if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL ar_next_valid: got %b required 1", outValid); end
        if (outData !== exp) begin bad++; $display("[TB] FAIL ar_next_data: got %h required %h", outData, exp); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit streamDone;
        int startCount;
        int w;
        streamDone = 1'b0;
        startCount = outCount;
        fork
            begin
                for (int s = 0; s < 1000; s++) begin
                    int len;
                    len = $urandom_range(1, NC);
                    for (int f = 0; f < len; f++) begin
                        while ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        sendFeature(WF'($urandom), (f == len - 1) && (len < NC || $urandom_range(0, 1) == 1));
                    end
                end
                streamDone = 1'b1;
            end
            begin
                while (!streamDone) begin
                    outReady = ($urandom_range(0, 9) < 6);
                    @(posedge clk);
                    #1;
                end
            end
        join
        outReady = 1'b1;
        w = 0;
        while ((sb.size() != 0 || outValid) && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        total += 2;
        if (sb.size() != 0 || outValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rand_drain: pending=%0d valid=%b required 0 and 0", sb.size(), outValid);
        end
        if (outCount - startCount != 1000) begin
            bad++;
            $display("[TB] FAIL rand_count: got %0d vectors required 1000", outCount - startCount);
        end
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inLast   = 1'b0;
        outReady = 1'b1;
        test_reset();
        test_full_sample();
        test_short_sample();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
